global_avg_pool: RTL
====================

Name: global_avg_pool

Overview:
- Reduces the final DS-block feature map to one INT8 value per channel: C channels × H×W pixels → C values.
- Sits between the last pointwise layer and the classifier layer of the DS-CNN inference path.
- Reads the ping-pong feature SRAM the last layer wrote. Writes C averaged values to the other bank, which the classifier reads as a 1×1×C input.
- Runs once per inference, started by a pulse; pulses done on completion.

Parameters:
- DATA_W, 8, feature element width (signed).
- ADDR_W, 14, feature SRAM address width.
- N_CH, 24, number of channels.
- FM_H, 25, input feature map height.
- FM_W, 20, input feature map width.
- ACC_W, 18, signed per-channel sum width; must hold FM_H*FM_W*2^(DATA_W-1).
- RECIP, 131, reciprocal multiplier, round(2^RECIP_SHIFT/(FM_H*FM_W)).
- RECIP_SHIFT, 16, right-shift applied after the reciprocal multiply.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins pooling; ignored unless idle.
- src_base  in  ADDR_W  base address of the input map; latched on accepted start.
- dst_base  in  ADDR_W  base address for the C outputs; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when all C outputs are written.
- rd_en  out  1  feature SRAM read strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  signed read data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  feature SRAM write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  signed write data.

Behaviour:
- Reset state: IDLE. busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data = 0; accumulator and counters cleared.
- Reset mid-operation: abort immediately, no further reads or writes, return to IDLE. A pending wr_en is not issued.
- Input memory layout is channel-major:
  - read address = src_base + c*FM_H*FM_W + p, with p = 0..FM_H*FM_W-1.
  - output for channel c goes to dst_base + c.
  - Addresses wrap modulo 2^ADDR_W.
- IDLE:
  - on start, latch src_base and dst_base, set c = 0, clear acc, go to READ.
  - start asserted in any other state is ignored.
- READ:
  - issue rd_en = 1 every cycle with sequential p, for FM_H*FM_W cycles.
  - a 1-cycle-delayed copy of rd_en qualifies rd_data; acc += sign-extended rd_data when the delayed strobe is set.
  - after the last address, go to DRAIN.
- DRAIN (1 cycle): rd_en = 0; accumulate the final sample.
- SCALE (1 cycle):
  - prod = acc * RECIP, signed, width ACC_W+RECIP_SHIFT.
  - add 2^(RECIP_SHIFT-1), then arithmetic shift right by RECIP_SHIFT.
  - saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; register into wr_data.
- WRITE (1 cycle):
  - wr_en = 1, wr_addr = dst_base + c; clear acc.
  - if c == N_CH-1 go to DONE; else c += 1 and go to READ.
- DONE (1 cycle): done = 1, busy = 0 on the next cycle, go to IDLE.
- Channel timing: FM_H*FM_W + 3 cycles per channel; never any gap in rd_en within a channel.
- Overall latency:
  - start sampled at edge k → first rd_en in cycle k+1.
  - done asserted in cycle k+1+N_CH*(FM_H*FM_W+3); for defaults, k+12073.
- rd_en and wr_en are never high in the same cycle.
- Exactly N_CH writes per run, at strictly increasing wr_addr.

Test Plan:
- All 12000 inputs = 100, src_base = 0, dst_base = 0x3000 → 24 writes of 100 at 0x3000..0x3017; done 12073 cycles after start.
- All inputs = -128 → every output -128 (sum -64000; rounding gives -127.43, floored to -128); no overflow.
- All inputs = 127 → every output 127; channel 5 only = 1 at a single pixel, others 0 → channel 5 output 0.
- Channel c pixels all = c-12 (c = 0..23) → wr_data sequence -12..11 in channel order; rd_addr covers 0..11999 with no gaps or repeats.
- start re-pulsed at cycle 500 of a run → ignored: write count stays 24, timing unchanged. Reset asserted at cycle 6000 → rd_en and wr_en drop the next cycle, busy = 0, no further writes; a new start then runs to completion normally.
- src_base = 0x3F00 (address wrap) → read addresses wrap modulo 16384, averages correct.

Source files
------------

// File: rtl/global_avg_pool_if.sv
// global_avg_pool_if: control/status and feature SRAM port bundle of global_avg_pool.
interface global_avg_pool_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) ();
    logic                     start;
    logic [ADDR_W-1:0]        src_base;
    logic [ADDR_W-1:0]        dst_base;
    logic                     busy;
    logic                     done;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    modport master (
        output start, src_base, dst_base, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  start, src_base, dst_base, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/global_avg_pool.sv
// global_avg_pool: per-channel mean of a channel-major INT8 feature map via reciprocal multiply.
module global_avg_pool #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 14,
    parameter int N_CH        = 24,
    parameter int FM_H        = 25,
    parameter int FM_W        = 20,
    parameter int ACC_W       = 18,
    parameter int RECIP       = 131,
    parameter int RECIP_SHIFT = 16
) (
    input logic              clk,
    input logic              reset,
    global_avg_pool_if.slave pool_io
);
    localparam int PIX    = FM_H * FM_W;
    localparam int P_W    = $clog2(PIX);
    localparam int C_W    = $clog2(N_CH);
    localparam int PROD_W = ACC_W + RECIP_SHIFT;
    localparam logic signed [PROD_W-1:0] MAX_V = PROD_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] MIN_V = PROD_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [2:0] {IDLE, READ, DRAIN, SCALE, WRITE, DONE} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ADDR_W-1:0]        dst_q, dst_d;
    logic [C_W-1:0]           c_q, c_d;
    logic [P_W-1:0]           p_q, p_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     rd_v_q;
    logic signed [DATA_W-1:0] wr_data_q, wr_data_d;
    logic signed [PROD_W-1:0] prod, rnd, avg;
    logic signed [DATA_W-1:0] sat;

    // base_q tracks src_base + c*PIX so the read address is a single add
    assign pool_io.busy    = state_q != IDLE;
    assign pool_io.done    = state_q == DONE;
    assign pool_io.rd_en   = state_q == READ;
    assign pool_io.rd_addr = base_q + ADDR_W'(p_q);
    assign pool_io.wr_en   = state_q == WRITE;
    assign pool_io.wr_addr = dst_q + ADDR_W'(c_q);
    assign pool_io.wr_data = wr_data_q;

    always_comb begin
        prod = PROD_W'(acc_q) * PROD_W'(RECIP);
        rnd  = prod + PROD_W'(2 ** (RECIP_SHIFT - 1));
        avg  = rnd >>> RECIP_SHIFT;
        sat  = avg > MAX_V ? DATA_W'(MAX_V) : avg < MIN_V ? DATA_W'(MIN_V) : avg[DATA_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        dst_d     = dst_q;
        c_d       = c_q;
        p_d       = p_q;
        wr_data_d = wr_data_q;
        acc_d     = rd_v_q ? acc_q + ACC_W'(pool_io.rd_data) : acc_q;
        unique case (state_q)
            IDLE: if (pool_io.start) begin
                state_d = READ;
                base_d  = pool_io.src_base;
                dst_d   = pool_io.dst_base;
                c_d     = '0;
                p_d     = '0;
                acc_d   = '0;
            end
            READ: begin
                p_d     = p_q == P_W'(PIX - 1) ? '0 : p_q + P_W'(1);
                state_d = p_q == P_W'(PIX - 1) ? DRAIN : READ;
            end
            DRAIN: state_d = SCALE;
            SCALE: begin
                wr_data_d = sat;
                state_d   = WRITE;
            end
            WRITE: begin
                acc_d   = '0;
                base_d  = base_q + ADDR_W'(PIX);
                state_d = c_q == C_W'(N_CH - 1) ? DONE : READ;
                c_d     = c_q == C_W'(N_CH - 1) ? c_q : c_q + C_W'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            dst_q     <= '0;
            c_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            rd_v_q    <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            dst_q     <= dst_d;
            c_q       <= c_d;
            p_q       <= p_d;
            acc_q     <= acc_d;
            rd_v_q    <= pool_io.rd_en;
            wr_data_q <= wr_data_d;
        end
    end
endmodule
